// File: rtl/sprite_load_pkg.sv
// Shared constants and FSM state type for the sprite BRAM loader.
package sprite_load_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned MEM_DEPTH_DEF = 13312;

  // Pixel = {PH[PIX_HI_W-1:0], PL[PIX_LO_W-1:0]}
  localparam int unsigned PIX_HI_W = 4;
  localparam int unsigned PIX_LO_W = 8;

  typedef enum logic [3:0] {
    StIdle,
    StAddr2,
    StAddr1,
    StAddr0,
    StLen1,
    StLen0,
    StPixHi,
    StPixLo,
    StCsum,
    StDrain
  } state_e;

endpackage

// File: rtl/sprite_mem_writer_if.sv
// Byte-stream input and BRAM write port of the sprite loader.
interface sprite_mem_writer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pixel_wr_fifo.sv
// Synchronous FIFO holding {addr, pixel} entries awaiting a BRAM write window.
module pixel_wr_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sprite_mem_writer.sv
// Parses framed pixel packets from a byte stream and commits them to the sprite BRAM
// only while wr_window is open.
module sprite_mem_writer
  import sprite_load_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_window,
  sprite_mem_writer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err_csum,
  output logic                err_range
);
  localparam int unsigned FIFO_W = ADDR_W + DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_cur_q, addr_cur_d;
  logic [15:0]         remain_q, remain_d;
  logic [7:0]          csum_q, csum_d;
  logic [PIX_HI_W-1:0] pix_hi_q, pix_hi_d;
  logic                err_csum_q, err_csum_d;
  logic                err_range_q, err_range_d;
  logic                done_q, done_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic              accept, in_range;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  // Plain full (not full && !pop) keeps in_ready off the write-window path.
  assign bus.in_ready = !((state_q == StDrain) || ((state_q == StPixLo) && fifo_full));
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_range     = 32'(addr_cur_q) < MEM_DEPTH;
  assign fifo_pop     = !fifo_empty && wr_window;
  assign fifo_wdata   = {addr_cur_q, DATA_W'({pix_hi_q, bus.in_data})};

  always_comb begin
    state_d     = state_q;
    addr_cur_d  = addr_cur_q;
    remain_d    = remain_q;
    csum_d      = csum_q;
    pix_hi_d    = pix_hi_q;
    err_csum_d  = err_csum_q;
    err_range_d = err_range_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && (bus.in_data == SYNC_BYTE)) begin
          err_csum_d  = 1'b0;
          err_range_d = 1'b0;
          csum_d      = 8'h00;
          state_d     = StAddr2;
        end
      end
      StAddr2: if (accept) begin
        addr_cur_d = ADDR_W'({bus.in_data[0], 16'h0000});
        state_d    = StAddr1;
      end
      StAddr1: if (accept) begin
        addr_cur_d[15:8] = bus.in_data;
        state_d          = StAddr0;
      end
      StAddr0: if (accept) begin
        addr_cur_d[7:0] = bus.in_data;
        state_d         = StLen1;
      end
      StLen1: if (accept) begin
        remain_d[15:8] = bus.in_data;
        state_d        = StLen0;
      end
      StLen0: if (accept) begin
        remain_d = {remain_q[15:8], bus.in_data};
        state_d  = (remain_d == 16'd0) ? StCsum : StPixHi;
      end
      StPixHi: if (accept) begin
        pix_hi_d = bus.in_data[PIX_HI_W-1:0];
        csum_d   = csum_q ^ bus.in_data;
        state_d  = StPixLo;
      end
      StPixLo: if (accept) begin
        csum_d = csum_q ^ bus.in_data;
        // Out-of-range pixels are consumed and checksummed but never stored.
        if (in_range) fifo_push   = 1'b1;
        else          err_range_d = 1'b1;
        addr_cur_d = addr_cur_q + ADDR_W'(1);
        remain_d   = remain_q - 16'd1;
        state_d    = (remain_q == 16'd1) ? StCsum : StPixHi;
      end
      StCsum: if (accept) begin
        if (bus.in_data != csum_q) err_csum_d = 1'b1;
        state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we_d    = fifo_pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (fifo_pop) begin
      mem_addr_d  = fifo_rdata[FIFO_W-1:DATA_W];
      mem_wdata_d = fifo_rdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_cur_q  <= '0;
      remain_q    <= '0;
      csum_q      <= '0;
      pix_hi_q    <= '0;
      err_csum_q  <= 1'b0;
      err_range_q <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_cur_q  <= addr_cur_d;
      remain_q    <= remain_d;
      csum_q      <= csum_d;
      pix_hi_q    <= pix_hi_d;
      err_csum_q  <= err_csum_d;
      err_range_q <= err_range_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  pixel_wr_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign err_csum      = err_csum_q;
  assign err_range     = err_range_q;

endmodule
